interrupt_factor_ctrl: RTL and testbench
========================================

Name: interrupt_factor_ctrl

Overview:
- Collects 16 peripheral event lines (timers, stopwatch, serial, K-port inputs) into four 4-bit interrupt factor groups, each with mask and edge-polarity registers.
- Drives the 15-bit `interrupt_req` level bus into the CPU core.
- Request bit k selects interrupt vector k+1 (bit 0 gives PCP/PCS low 0x01, bit 14 gives 0x0F). The CPU does priority and vectoring.
- Software accesses the factor, mask and polarity registers through a nibble-wide I/O register port. Reading a factor register clears it.

Parameters:
- VEC_G0, 14, `interrupt_req` bit driven by group 0 (vector 0x0F).
- VEC_G1, 11, `interrupt_req` bit driven by group 1 (vector 0x0C).
- VEC_G2, 6, `interrupt_req` bit driven by group 2 (vector 0x07).
- VEC_G3, 0, `interrupt_req` bit driven by group 3 (vector 0x01).
- SETTLE_CYCLES, 3, number of cycles after reset during which edge detection is suppressed.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- event_in  in  16  raw event levels; bit 4g+i is group g, bit i; asynchronous to clk
- bus_addr  in  4  register address
- bus_wr  in  1  write strobe, one cycle
- bus_rd  in  1  read strobe, one cycle
- bus_wr_data  in  4  write data
- bus_rd_data  out  4  read data, registered
- interrupt_req  out  15  level request lines to the CPU
- flags  out  16  current factor flags (debug and test)

Behaviour:
- Reset (async, active-high): factor flags, masks, polarity, both synchronizer stages, `prev` sample register, `bus_rd_data` and `interrupt_req` all go to 0. The settle counter loads SETTLE_CYCLES.
- Synchronizer: two flops per event bit (`s1` then `s2`), followed by `prev` (last value of `s2`).
- Edge detection, per bit b:
  - polarity 0: rising edge, `edge[b] = s2 & ~prev`.
  - polarity 1: falling edge, `edge[b] = ~s2 & prev`.
- Settle counter: decrements once per cycle while nonzero. While it is nonzero, `prev` tracks `s2` and `edge` is forced to 0. This prevents idle-high inputs from raising spurious flags after reset.
- Factor flag update: `flag[b]` sets on the edge where `edge[b] = 1`. It holds until cleared by a read of its group.
- Latency: an event change captured at edge E0 reaches `s2` at E1, sets the flag at E2, and `interrupt_req` rises at E3.
- Register map (g = 0..3):
  - 0x0+g: factor group g. Read-only; writes are ignored. A read returns the flags and clears all 4 flags of the group on the same edge.
  - 0x4+g: mask group g. Read/write; 1 = enabled.
  - 0x8+g: polarity group g. Read/write.
  - 0xC–0xF: read 0; writes are ignored.
- Read timing: `bus_rd` sampled at edge N loads `bus_rd_data` at edge N. Data is valid from N until the next read strobe; otherwise `bus_rd_data` holds its value.
- Set/clear collision: if a factor read and an edge on bit b fall on the same cycle, set wins. `flag[b]` remains 1 and the read returns the pre-edge value 0, so the event is never lost.
- `bus_rd` and `bus_wr` together: both take effect. The read returns the old register value.
- Mask writes take effect at the write edge. `interrupt_req` follows on the next edge.
- Request generation: `interrupt_req[k]` is registered and equals the OR, over every group g with VEC_Gg == k, of `|(flag_g & mask_g)`. Unmapped bits are 0.
- Level semantics:
  - The request stays high as long as an enabled flag is set, including across the CPU's interrupt entry. Software must read the factor register to drop it.
  - Masking a set flag drops the request one edge after the mask write. The flag stays set, and unmasking re-raises the request.
- Polarity change: `prev` is not altered. A polarity write that makes the current `s2`/`prev` pair read as an edge does not set a flag, because edge detection is suppressed for the one cycle following any polarity write.
- Reset asserted mid-operation clears everything immediately, including any pending read data.

Test Plan:
1. Reset release, `event_in` held at 16'hFFFF with polarity 0 → `flags` stays 16'h0000 forever; `interrupt_req` = 0.
2. Mask0 = 4'h1, pulse `event_in[0]` high for 1 cycle → flag0[0] set at E2, `interrupt_req` = 15'h4000 at E3. Read 0x0 → `bus_rd_data` = 4'h1, flags cleared, `interrupt_req` = 0 one edge later.
3. Polarity3 = 4'h8, mask3 = 4'h8, `event_in[15]` falls → `interrupt_req` = 15'h0001. A rise of `event_in[15]` alone sets no flag.
4. Flag2[1] set, mask2 = 0 → `interrupt_req` = 0. Write mask2 = 4'h2 → `interrupt_req` = 15'h0040 on the next edge.
5. Edge on `event_in[4]` coincident with a read of 0x1 → `bus_rd_data` = 4'h0, `flags[4]` = 1 afterwards, `interrupt_req[11]` remains high if mask1[0] = 1.
6. Assert reset while `interrupt_req` = 15'h0800 → `interrupt_req`, `flags` and `bus_rd_data` are 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/interrupt_factor_ctrl.sv
// rtl/interrupt_factor_ctrl.sv - four 4-bit interrupt factor groups with mask/polarity and level request bus
module interrupt_factor_ctrl #(
  parameter int VEC_G0        = 14,
  parameter int VEC_G1        = 11,
  parameter int VEC_G2        = 6,
  parameter int VEC_G3        = 0,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] event_in,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [3:0]  bus_wr_data,
  output logic [3:0]  bus_rd_data,
  output logic [14:0] interrupt_req,
  output logic [15:0] flags
);

  localparam int SCW = $clog2(SETTLE_CYCLES + 2);

  logic [15:0]    s1, s2, prev;
  logic [15:0]    mask_r, pol_r;
  logic [SCW-1:0] settle_cnt;
  logic           pol_block;

  logic [15:0]    edge_raw, edge_det, clr_vec, flags_next;
  logic [3:0]     grp_base;
  logic [3:0]     rd_mux;
  logic [3:0]     grp_any;
  logic [14:0]    req_next;
  logic           mask_wr, pol_wr, fac_rd;

  assign grp_base = {bus_addr[1:0], 2'b00};
  assign mask_wr  = bus_wr && (bus_addr[3:2] == 2'd1);
  assign pol_wr   = bus_wr && (bus_addr[3:2] == 2'd2);
  assign fac_rd   = bus_rd && (bus_addr[3:2] == 2'd0);

  // Polarity 0 detects rising, 1 detects falling; quiet while settling or just after a polarity write.
  assign edge_raw = (s2 & ~prev & ~pol_r) | (~s2 & prev & pol_r);
  assign edge_det = ((settle_cnt != '0) || pol_block) ? 16'h0000 : edge_raw;

  // Set beats clear so an event coinciding with a factor read is never lost.
  assign clr_vec    = fac_rd ? (16'h000F << grp_base) : 16'h0000;
  assign flags_next = (flags & ~clr_vec) | edge_det;

  always_comb begin
    rd_mux = 4'h0;
    case (bus_addr[3:2])
      2'd0:    rd_mux = flags[grp_base +: 4];
      2'd1:    rd_mux = mask_r[grp_base +: 4];
      2'd2:    rd_mux = pol_r[grp_base +: 4];
      default: rd_mux = 4'h0;
    endcase
  end

  always_comb begin
    grp_any = 4'h0;
    for (int g = 0; g < 4; g++) begin
      grp_any[g] = |(flags[4*g +: 4] & mask_r[4*g +: 4]);
    end
  end

  always_comb begin
    req_next = 15'h0000;
    for (int k = 0; k < 15; k++) begin
      req_next[k] = ((VEC_G0 == k) && grp_any[0]) ||
                    ((VEC_G1 == k) && grp_any[1]) ||
                    ((VEC_G2 == k) && grp_any[2]) ||
                    ((VEC_G3 == k) && grp_any[3]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1            <= 16'h0000;
      s2            <= 16'h0000;
      prev          <= 16'h0000;
      settle_cnt    <= SCW'(SETTLE_CYCLES);
      pol_block     <= 1'b0;
      flags         <= 16'h0000;
      mask_r        <= 16'h0000;
      pol_r         <= 16'h0000;
      bus_rd_data   <= 4'h0;
      interrupt_req <= 15'h0000;
    end else begin
      s1        <= event_in;
      s2        <= s1;
      prev      <= s2;
      pol_block <= pol_wr;
      if (settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      flags <= flags_next;
      if (mask_wr) begin
        mask_r[grp_base +: 4] <= bus_wr_data;
      end
      if (pol_wr) begin
        pol_r[grp_base +: 4] <= bus_wr_data;
      end
      if (bus_rd) begin
        bus_rd_data <= rd_mux;
      end
      interrupt_req <= req_next;
    end
  end

endmodule

// File: tb/tb_interrupt_factor_ctrl.sv
// tb/tb_interrupt_factor_ctrl.sv - scoreboard bench for interrupt_factor_ctrl
module tb_interrupt_factor_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] event_in;
  logic [3:0]  bus_addr;
  logic        bus_wr;
  logic        bus_rd;
  logic [3:0]  bus_wr_data;
  logic [3:0]  bus_rd_data;
  logic [14:0] interrupt_req;
  logic [15:0] flags;

  interrupt_factor_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .event_in     (event_in),
    .bus_addr     (bus_addr),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_wr_data  (bus_wr_data),
    .bus_rd_data  (bus_rd_data),
    .interrupt_req(interrupt_req),
    .flags        (flags)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [14:0] req;
    logic [15:0] flg;
    logic [3:0]  rd;
    bit          chk_rd;
  } obs_t;

  typedef struct {
    string      name;
    logic [3:0] rd;
  } rd_t;

  obs_t obs_q[$];
  rd_t  rd_q[$];
  event probe_ev;
  logic rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= bus_rd;

  always @(negedge clk) begin : rd_mon
    rd_t e;
    if (rd_seen) begin
      tests_run++;
      if (rd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_unexpected: got %h, no read expected", bus_rd_data);
      end else begin
        e = rd_q.pop_front();
        if (bus_rd_data !== e.rd) begin
          tests_failed++;
          $display("FAIL %s: bus_rd_data=%h required %h", e.name, bus_rd_data, e.rd);
        end
      end
    end
  end

  always @(probe_ev) begin : obs_mon
    obs_t o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      tests_run++;
      if (interrupt_req !== o.req) begin
        tests_failed++;
        $display("FAIL %s.req: interrupt_req=%h required %h", o.name, interrupt_req, o.req);
      end
      tests_run++;
      if (flags !== o.flg) begin
        tests_failed++;
        $display("FAIL %s.flags: flags=%h required %h", o.name, flags, o.flg);
      end
      if (o.chk_rd) begin
        tests_run++;
        if (bus_rd_data !== o.rd) begin
          tests_failed++;
          $display("FAIL %s.rd: bus_rd_data=%h required %h", o.name, bus_rd_data, o.rd);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe(input string name, input logic [14:0] req, input logic [15:0] flg,
                       input bit chk_rd = 1'b0, input logic [3:0] rd = 4'h0);
    obs_t o;
    o.name = name; o.req = req; o.flg = flg; o.rd = rd; o.chk_rd = chk_rd;
    obs_q.push_back(o);
    -> probe_ev;
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    bus_addr = a; bus_wr_data = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [3:0] exp);
    rd_t e;
    e.name = name; e.rd = exp;
    rd_q.push_back(e);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
  endtask

  task automatic rdwr(input string name, input logic [3:0] a, input logic [3:0] d,
                      input logic [3:0] exp);
    rd_t e;
    e.name = name; e.rd = exp;
    rd_q.push_back(e);
    bus_addr = a; bus_wr_data = d; bus_rd = 1'b1; bus_wr = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0; bus_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; event_in = 16'hFFFF;
    bus_addr = 4'h0; bus_wr = 1'b0; bus_rd = 1'b0; bus_wr_data = 4'h0;

    // idle-high inputs across reset release must not raise flags
    tick(3);
    probe("reset_state", 15'h0000, 16'h0000, 1'b1, 4'h0);
    reset = 1'b0;
    tick(10);
    probe("settle_high", 15'h0000, 16'h0000);
    event_in = 16'h0000;
    tick(5);
    probe("fall_pol0", 15'h0000, 16'h0000);

    // group 0 rising pulse, latency and read-clear
    wr(4'h4, 4'h1);
    tick(1);
    event_in[0] = 1'b1;
    tick(1);
    event_in[0] = 1'b0;
    tick(1);
    probe("g0_e1", 15'h0000, 16'h0000);
    tick(1);
    probe("g0_e2", 15'h0000, 16'h0001);
    tick(1);
    probe("g0_e3", 15'h4000, 16'h0001);
    rd("g0_read", 4'h0, 4'h1);
    probe("g0_after_rd", 15'h4000, 16'h0000);
    tick(1);
    probe("g0_req_drop", 15'h0000, 16'h0000);
    rd("g0_reread", 4'h0, 4'h0);

    // group 3 falling polarity
    wr(4'hB, 4'h8);
    wr(4'h7, 4'h8);
    tick(2);
    event_in[15] = 1'b1;
    tick(5);
    probe("g3_rise_ignored", 15'h0000, 16'h0000);
    event_in[15] = 1'b0;
    tick(3);
    probe("g3_fall_e2", 15'h0000, 16'h8000);
    tick(1);
    probe("g3_fall_e3", 15'h0001, 16'h8000);
    rd("g3_read", 4'h3, 4'h8);
    tick(1);
    probe("g3_cleared", 15'h0000, 16'h0000);

    // polarity write landing on a transition must not create a flag
    wr(4'hA, 4'h1);
    tick(2);
    event_in[8] = 1'b1;
    tick(1);
    wr(4'hA, 4'h0);
    tick(3);
    probe("pol_change_suppress", 15'h0000, 16'h0000);
    event_in[8] = 1'b0;
    tick(4);
    probe("g2_fall_pol0", 15'h0000, 16'h0000);

    // group 2 masking
    event_in[9] = 1'b1;
    tick(1);
    event_in[9] = 1'b0;
    tick(4);
    probe("g2_masked", 15'h0000, 16'h0200);
    rd("mask2_rb0", 4'h6, 4'h0);
    wr(4'h6, 4'h2);
    probe("g2_mask_edge", 15'h0000, 16'h0200);
    tick(1);
    probe("g2_unmasked", 15'h0040, 16'h0200);
    wr(4'h6, 4'h0);
    tick(1);
    probe("g2_remasked", 15'h0000, 16'h0200);
    wr(4'h6, 4'h2);
    tick(1);
    probe("g2_reraise", 15'h0040, 16'h0200);
    rdwr("mask2_rdwr", 4'h6, 4'h5, 4'h2);
    rd("mask2_rb5", 4'h6, 4'h5);
    tick(1);
    probe("g2_mask5", 15'h0000, 16'h0200);
    rd("g2_read", 4'h2, 4'h2);
    tick(1);
    probe("g2_cleared", 15'h0000, 16'h0000);
    wr(4'h6, 4'h0);
    wr(4'h0, 4'hF);
    wr(4'hC, 4'hF);
    rd("unmapped_rd", 4'hC, 4'h0);
    rd("fac0_ro", 4'h0, 4'h0);
    probe("ro_writes", 15'h0000, 16'h0000);

    // set/clear collision on group 1
    wr(4'h5, 4'h1);
    tick(1);
    event_in[4] = 1'b1;
    tick(2);
    rd("collide_rd", 4'h1, 4'h0);
    probe("collide_flag", 15'h0000, 16'h0010);
    tick(1);
    probe("collide_req", 15'h0800, 16'h0010);
    tick(2);
    probe("collide_hold", 15'h0800, 16'h0010);
    rd("mask1_rb", 4'h5, 4'h1);

    // asynchronous reset mid-operation
    tick(1);
    #2;
    reset = 1'b1;
    #1;
    probe("async_reset", 15'h0000, 16'h0000, 1'b1, 4'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    probe("post_reset_settle", 15'h0000, 16'h0000, 1'b1, 4'h0);

    tick(2);
    tests_run++;
    if (rd_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rd_q_drain: %0d reads pending, required 0", rd_q.size());
    end
    tests_run++;
    if (obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL obs_q_drain: %0d probes pending, required 0", obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
